decode_stage_hs: RTL and testbench

Parametrised MIPS instruction-decode stage with valid/ready handshakes on both sides. It replaces the free-running decode register with a stallable, flushable pipeline register. Internally it holds the register file with write-through bypass, detects load-use and branch-operand hazards, and resolves J/JAL/JR/JALR/BEQ/BNE in ID with a single-cycle redirect to fetch. It sits between the fetch stage (upstream) and the execute stage (downstream).

---
 rtl/mips_pkg.sv | 77 +++++++
 rtl/id_regfile.sv | 51 +++++
 rtl/decode_stage_hs.sv | 228 ++++++++++++++++++++++
 tb/tb_decode_stage_hs.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, function codes, and the layout of
// the control bundle that travels from ID to EX.
package mips_pkg;

    // Control bundle width and bit positions
    localparam int NB_CTRL        = 14;
    localparam int CTRL_REGWRITE  = 0;
    localparam int CTRL_MEM2REG   = 1;
    localparam int CTRL_MEMREAD   = 2;
    localparam int CTRL_MEMWRITE  = 3;
    localparam int CTRL_IMMEDIATE = 4;
    localparam int CTRL_SIGN      = 5;
    localparam int CTRL_ALUSRC    = 6;   // [7:6]
    localparam int CTRL_ALUOP     = 8;   // [9:8]
    localparam int CTRL_WIDTH     = 10;  // [11:10]
    localparam int CTRL_REGDST    = 12;
    localparam int CTRL_LINK      = 13;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes that ID cares about
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;

    typedef enum logic [1:0] {
        ALUSRC_REG   = 2'd0,
        ALUSRC_IMM   = 2'd1,
        ALUSRC_SHAMT = 2'd2
    } alusrc_e;

    typedef enum logic [1:0] {
        ALUOP_ADD = 2'd0,
        ALUOP_SUB = 2'd1,
        ALUOP_R   = 2'd2,   // EX looks at func
        ALUOP_IMM = 2'd3    // EX looks at opcode
    } aluop_e;

    typedef enum logic [1:0] {
        W_BYTE = 2'd0,
        W_HALF = 2'd1,
        W_WORD = 2'd3
    } width_e;

    // Load/store opcodes encode access size in their two low bits
    function automatic width_e mem_width(input logic [5:0] op);
        case (op[1:0])
            2'b00:   mem_width = W_BYTE;
            2'b01:   mem_width = W_HALF;
            default: mem_width = W_WORD;
        endcase
    endfunction

endpackage

// File: rtl/id_regfile.sv
// 2-read / 1-write register file. x0 is hardwired to zero, and a read of the
// entry being written this cycle returns the incoming write data.
module id_regfile
    import mips_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 5
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_we,
    input  logic [NB_ADDR-1:0] i_waddr,
    input  logic [NB_DATA-1:0] i_wdata,
    input  logic [NB_ADDR-1:0] i_raddr_a,
    input  logic [NB_ADDR-1:0] i_raddr_b,
    output logic [NB_DATA-1:0] o_rdata_a,
    output logic [NB_DATA-1:0] o_rdata_b
);

    localparam int NREGS = 2 ** NB_ADDR;

    logic [NB_DATA-1:0] mem_q [0:NREGS-1];

    // Storage: cleared on reset, writes to x0 dropped
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
        end else if (i_we && i_waddr != '0) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    // Read port A with write-through bypass
    always_comb begin
        o_rdata_a = mem_q[i_raddr_a];
        if (i_raddr_a == '0)
            o_rdata_a = '0;
        else if (i_we && i_raddr_a == i_waddr)
            o_rdata_a = i_wdata;
    end

    // Read port B with write-through bypass
    always_comb begin
        o_rdata_b = mem_q[i_raddr_b];
        if (i_raddr_b == '0)
            o_rdata_b = '0;
        else if (i_we && i_raddr_b == i_waddr)
            o_rdata_b = i_wdata;
    end

endmodule

// File: rtl/decode_stage_hs.sv
// MIPS instruction-decode stage with valid/ready on both sides. Decodes the
// incoming word, stalls on load-use and branch-operand hazards, resolves
// jumps/branches in ID with a one-cycle redirect, and holds the ID/EX
// register until execute takes it.
module decode_stage_hs
    import mips_pkg::*;
#(
    parameter int NB_DATA  = 32,
    parameter int NB_ADDR  = 5,
    parameter int LINK_REG = 31
) (
    input  logic               clk,
    input  logic               i_rst_n,
    // fetch side
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [NB_DATA-1:0] i_instruction,
    input  logic [NB_DATA-1:0] i_pcounter4,
    input  logic               i_flush,
    // writeback port
    input  logic               i_wb_we,
    input  logic [NB_ADDR-1:0] i_wb_addr,
    input  logic [NB_DATA-1:0] i_wb_data,
    // instruction in EX
    input  logic               i_ex_memRead,
    input  logic               i_ex_regWrite,
    input  logic [NB_ADDR-1:0] i_ex_wr_addr,
    // MEM-stage forward for branch compare
    input  logic               i_mem_regWrite,
    input  logic [NB_ADDR-1:0] i_mem_wr_addr,
    input  logic [NB_DATA-1:0] i_mem_data,
    // execute side
    output logic               o_valid,
    input  logic               i_ready,
    output logic [NB_ADDR-1:0] o_rs,
    output logic [NB_ADDR-1:0] o_rt,
    output logic [NB_ADDR-1:0] o_rd,
    output logic [NB_DATA-1:0] o_reg_DA,
    output logic [NB_DATA-1:0] o_reg_DB,
    output logic [NB_DATA-1:0] o_immediate,
    output logic [5:0]         o_opcode,
    output logic [4:0]         o_shamt,
    output logic [5:0]         o_func,
    output logic [NB_CTRL-1:0] o_ctrl,
    // redirect to fetch
    output logic               o_redirect,
    output logic [NB_DATA-1:0] o_redirect_addr
);

    // Instruction fields
    logic [5:0]         op, fn;
    logic [NB_ADDR-1:0] rs, rt, rd_fld;
    assign op     = i_instruction[31:26];
    assign fn     = i_instruction[5:0];
    assign rs     = i_instruction[25:21];
    assign rt     = i_instruction[20:16];
    assign rd_fld = i_instruction[15:11];

    logic [NB_DATA-1:0] rf_a, rf_b;

    id_regfile #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) u_rf (
        .clk       (clk),
        .i_rst_n   (i_rst_n),
        .i_we      (i_wb_we),
        .i_waddr   (i_wb_addr),
        .i_wdata   (i_wb_data),
        .i_raddr_a (rs),
        .i_raddr_b (rt),
        .o_rdata_a (rf_a),
        .o_rdata_b (rf_b)
    );

    logic [NB_CTRL-1:0] ctrl_d;
    logic reads_rs, reads_rt, is_branch, is_jr, is_j, is_link;

    // Control decode; unknown opcodes fall through as an all-zero bundle
    always_comb begin
        ctrl_d    = '0;
        reads_rs  = 1'b1;
        reads_rt  = 1'b0;
        is_branch = 1'b0;
        is_jr     = 1'b0;
        is_j      = 1'b0;
        is_link   = 1'b0;
        case (op)
            OP_RTYPE: begin
                if (fn == FN_JR) begin
                    is_jr = 1'b1;
                end else if (fn == FN_JALR) begin
                    is_jr   = 1'b1;
                    is_link = 1'b1;
                    ctrl_d[CTRL_REGWRITE] = 1'b1;
                    ctrl_d[CTRL_REGDST]   = 1'b1;
                    ctrl_d[CTRL_LINK]     = 1'b1;
                end else begin
                    reads_rt = 1'b1;
                    ctrl_d[CTRL_REGWRITE]   = 1'b1;
                    ctrl_d[CTRL_REGDST]     = 1'b1;
                    ctrl_d[CTRL_ALUOP +: 2] = ALUOP_R;
                    if (fn == FN_SLL || fn == FN_SRL || fn == FN_SRA)
                        ctrl_d[CTRL_ALUSRC +: 2] = ALUSRC_SHAMT;
                end
            end
            OP_J: begin
                is_j     = 1'b1;
                reads_rs = 1'b0;
            end
            OP_JAL: begin
                is_j     = 1'b1;
                is_link  = 1'b1;
                reads_rs = 1'b0;
                ctrl_d[CTRL_REGWRITE] = 1'b1;
                ctrl_d[CTRL_LINK]     = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                is_branch = 1'b1;
                reads_rt  = 1'b1;
                ctrl_d[CTRL_SIGN]       = 1'b1;
                ctrl_d[CTRL_ALUOP +: 2] = ALUOP_SUB;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl_d[CTRL_REGWRITE]    = 1'b1;
                ctrl_d[CTRL_IMMEDIATE]   = 1'b1;
                ctrl_d[CTRL_ALUSRC +: 2] = ALUSRC_IMM;
                ctrl_d[CTRL_ALUOP +: 2]  = ALUOP_IMM;
                // logical ops and LUI take a zero-extended immediate
                ctrl_d[CTRL_SIGN]        = (op[5:2] == 4'b0010);
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                ctrl_d[CTRL_REGWRITE]    = 1'b1;
                ctrl_d[CTRL_MEM2REG]     = 1'b1;
                ctrl_d[CTRL_MEMREAD]     = 1'b1;
                ctrl_d[CTRL_IMMEDIATE]   = 1'b1;
                ctrl_d[CTRL_SIGN]        = 1'b1;
                ctrl_d[CTRL_ALUSRC +: 2] = ALUSRC_IMM;
                ctrl_d[CTRL_WIDTH +: 2]  = mem_width(op);
            end
            OP_SB, OP_SH, OP_SW: begin
                reads_rt = 1'b1;
                ctrl_d[CTRL_MEMWRITE]    = 1'b1;
                ctrl_d[CTRL_IMMEDIATE]   = 1'b1;
                ctrl_d[CTRL_SIGN]        = 1'b1;
                ctrl_d[CTRL_ALUSRC +: 2] = ALUSRC_IMM;
                ctrl_d[CTRL_WIDTH +: 2]  = mem_width(op);
            end
            default: ;
        endcase
    end

    logic [NB_DATA-1:0] imm_sext, imm_zext, cmp_a, cmp_b, redir_addr_d;
    logic               hazard, taken, redir_req, accept, valid_q;

    assign imm_sext = {{(NB_DATA-16){i_instruction[15]}}, i_instruction[15:0]};
    assign imm_zext = {{(NB_DATA-16){1'b0}}, i_instruction[15:0]};

    // Hazard detection, branch operand forwarding and redirect target
    always_comb begin
        logic ex_hit_rs, ex_hit_rt, load_use, br_haz;
        ex_hit_rs = (i_ex_wr_addr != '0) && (i_ex_wr_addr == rs) && reads_rs;
        ex_hit_rt = (i_ex_wr_addr != '0) && (i_ex_wr_addr == rt);
        load_use  = i_ex_memRead && (ex_hit_rs || (reads_rt && ex_hit_rt));
        // branches and register jumps consume operands in ID, so any EX
        // producer of those registers must retire first
        br_haz    = i_ex_regWrite &&
                    ((is_branch && (ex_hit_rs || ex_hit_rt)) || (is_jr && ex_hit_rs));
        hazard    = load_use || br_haz;

        cmp_a = rf_a;
        cmp_b = rf_b;
        if (i_mem_regWrite && i_mem_wr_addr != '0 && i_mem_wr_addr == rs) cmp_a = i_mem_data;
        if (i_mem_regWrite && i_mem_wr_addr != '0 && i_mem_wr_addr == rt) cmp_b = i_mem_data;

        taken     = (op == OP_BEQ) ? (cmp_a == cmp_b) : (cmp_a != cmp_b);
        redir_req = is_j || is_jr || (is_branch && taken);

        if (is_j)
            redir_addr_d = {i_pcounter4[NB_DATA-1:28], i_instruction[25:0], 2'b00};
        else if (is_jr)
            redir_addr_d = cmp_a;
        else
            redir_addr_d = i_pcounter4 + {imm_sext[NB_DATA-3:0], 2'b00};
    end

    assign o_ready         = !i_flush && (!valid_q || i_ready) && !hazard;
    assign accept          = i_valid && o_ready;
    assign o_redirect      = accept && redir_req;
    assign o_redirect_addr = redir_addr_d;
    assign o_valid         = valid_q;

    // ID/EX register: valid tracks the handshake, payload loads only on accept
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q     <= 1'b0;
            o_rs        <= '0;
            o_rt        <= '0;
            o_rd        <= '0;
            o_reg_DA    <= '0;
            o_reg_DB    <= '0;
            o_immediate <= '0;
            o_opcode    <= '0;
            o_shamt     <= '0;
            o_func      <= '0;
            o_ctrl      <= '0;
        end else begin
            if (i_flush)
                valid_q <= 1'b0;
            else if (accept)
                valid_q <= 1'b1;
            else if (valid_q && i_ready)
                valid_q <= 1'b0;

            if (accept) begin
                o_rs        <= rs;
                o_rt        <= rt;
                o_rd        <= (op == OP_JAL) ? NB_ADDR'(LINK_REG) : rd_fld;
                o_reg_DA    <= is_link ? i_pcounter4 : rf_a;
                o_reg_DB    <= is_link ? '0 : rf_b;
                o_immediate <= ctrl_d[CTRL_SIGN] ? imm_sext : imm_zext;
                o_opcode    <= op;
                o_shamt     <= i_instruction[10:6];
                o_func      <= fn;
                o_ctrl      <= ctrl_d;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage_hs.sv
// Directed bench for decode_stage_hs: stimulus pushes expected ID/EX payloads
// into a queue; a negedge monitor pops and compares on every EX transfer.
module tb_decode_stage_hs;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid, o_ready, i_flush, i_ready, o_valid;
    logic [31:0] i_instruction, i_pcounter4;
    logic        i_wb_we;
    logic [4:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic        i_ex_memRead, i_ex_regWrite;
    logic [4:0]  i_ex_wr_addr;
    logic        i_mem_regWrite;
    logic [4:0]  i_mem_wr_addr;
    logic [31:0] i_mem_data;
    logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
    logic [31:0] o_reg_DA, o_reg_DB, o_immediate, o_redirect_addr;
    logic [5:0]  o_opcode, o_func;
    logic [13:0] o_ctrl;
    logic        o_redirect;

    always #5 clk = ~clk;

    decode_stage_hs dut (
        .clk(clk), .i_rst_n(i_rst_n),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_instruction(i_instruction), .i_pcounter4(i_pcounter4), .i_flush(i_flush),
        .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .i_ex_memRead(i_ex_memRead), .i_ex_regWrite(i_ex_regWrite), .i_ex_wr_addr(i_ex_wr_addr),
        .i_mem_regWrite(i_mem_regWrite), .i_mem_wr_addr(i_mem_wr_addr), .i_mem_data(i_mem_data),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
        .o_reg_DA(o_reg_DA), .o_reg_DB(o_reg_DB), .o_immediate(o_immediate),
        .o_opcode(o_opcode), .o_shamt(o_shamt), .o_func(o_func), .o_ctrl(o_ctrl),
        .o_redirect(o_redirect), .o_redirect_addr(o_redirect_addr)
    );

    typedef struct {
        logic [4:0]  rs, rt, rd;
        logic [31:0] da, db, imm;
        logic [13:0] ctrl;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    function automatic exp_t mk(input logic [4:0] rs, rt, rd,
                                input logic [31:0] da, db, imm, input logic [13:0] ctrl);
        exp_t e;
        e.rs = rs; e.rt = rt; e.rd = rd; e.da = da; e.db = db; e.imm = imm; e.ctrl = ctrl;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every cycle EX takes a word, compare against the oldest expectation
    always @(negedge clk) begin
        if (i_rst_n && o_valid && i_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got o_valid=1 with opcode 0x%0h, expected no pending item", o_opcode);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_rs",   o_rs,        e.rs);
                chk("out_rt",   o_rt,        e.rt);
                chk("out_rd",   o_rd,        e.rd);
                chk("out_DA",   o_reg_DA,    e.da);
                chk("out_DB",   o_reg_DB,    e.db);
                chk("out_imm",  o_immediate, e.imm);
                chk("out_ctrl", o_ctrl,      e.ctrl);
            end
        end
    end

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        i_wb_we = 1'b1; i_wb_addr = a; i_wb_data = d;
        @(posedge clk); #1;
        i_wb_we = 1'b0;
    endtask

    // Present one instruction until accepted; check redirect at the accepting edge
    task automatic send(input logic [31:0] ins, input logic [31:0] pc4, input exp_t e,
                        input bit push, input bit er, input logic [31:0] ea, output int waited);
        bit done;
        done   = 1'b0;
        waited = 0;
        i_valid = 1'b1; i_instruction = ins; i_pcounter4 = pc4;
        for (int k = 0; k < 10 && !done; k++) begin
            @(negedge clk);
            if (o_ready) begin
                chk("redirect", o_redirect, er);
                if (er) chk("redirect_addr", o_redirect_addr, ea);
                if (push) sb.push_back(e);
                done = 1'b1;
            end else begin
                waited++;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: instr 0x%08h got no accept, expected accept within 10 cycles", ins);
        end
        i_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        i_rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
        i_instruction = '0; i_pcounter4 = '0;
        i_wb_we = 1'b0; i_wb_addr = '0; i_wb_data = '0;
        i_ex_memRead = 1'b0; i_ex_regWrite = 1'b0; i_ex_wr_addr = '0;
        i_mem_regWrite = 1'b0; i_mem_wr_addr = '0; i_mem_data = '0;

        // reset state
        #2;
        chk("rst_valid", o_valid, 0);
        chk("rst_ready", o_ready, 1);
        chk("rst_DA", o_reg_DA, 0);
        chk("rst_ctrl", o_ctrl, 0);
        @(posedge clk); #1;
        i_rst_n = 1'b1;

        // register file contents
        wb(5'd5, 32'h1234);
        wb(5'd1, 32'h11);
        wb(5'd0, 32'hDEAD);

        // add x3,x5,x0
        send(32'h00A01820, 32'h4, mk(5, 0, 3, 32'h1234, 0, 32'h1820, 14'h1201), 1, 0, 0, w);

        // load-use: lw x2 in EX while add x4,x2,x1 sits in ID
        i_valid = 1'b1; i_instruction = 32'h00412020; i_pcounter4 = 32'h8;
        i_ex_memRead = 1'b1; i_ex_regWrite = 1'b1; i_ex_wr_addr = 5'd2;
        @(negedge clk);
        chk("loaduse_ready", o_ready, 0);
        @(posedge clk); #1;
        i_ex_memRead = 1'b0; i_ex_regWrite = 1'b0; i_ex_wr_addr = '0;
        chk("loaduse_bubble", o_valid, 0);
        send(32'h00412020, 32'h8, mk(2, 1, 4, 0, 32'h11, 32'h2020, 14'h1201), 1, 0, 0, w);
        chk("loaduse_extra_wait", w, 0);

        // branches
        send(32'h10210003, 32'h100, mk(1, 1, 0, 32'h11, 32'h11, 3, 14'h120), 1, 1, 32'h10C, w);
        send(32'h14210003, 32'h104, mk(1, 1, 0, 32'h11, 32'h11, 3, 14'h120), 1, 0, 0, w);

        // jal 0x40
        send(32'h0C000040, 32'h2004, mk(0, 0, 31, 32'h2004, 0, 32'h40, 14'h2001), 1, 1, 32'h100, w);

        // beq x1,x6,-1 taken only via MEM forward of x6=0x11
        i_mem_regWrite = 1'b1; i_mem_wr_addr = 5'd6; i_mem_data = 32'h11;
        send(32'h1026FFFF, 32'h200, mk(1, 6, 31, 32'h11, 0, 32'hFFFFFFFF, 14'h120), 1, 1, 32'h1FC, w);
        i_mem_regWrite = 1'b0;

        // ori x8,x0,0x8000 (zero-extended) then an unknown opcode
        send(32'h34088000, 32'h204, mk(0, 8, 16, 0, 0, 32'h8000, 14'h351), 1, 0, 0, w);
        send(32'hFC000000, 32'h208, mk(0, 0, 0, 0, 0, 0, 14'h0), 1, 0, 0, w);

        // write-through: WB x7=0xAA in the same cycle add x9,x7,x0 is decoded
        i_wb_we = 1'b1; i_wb_addr = 5'd7; i_wb_data = 32'hAA;
        send(32'h00E04820, 32'h20C, mk(7, 0, 9, 32'hAA, 0, 32'h4820, 14'h1201), 1, 0, 0, w);
        i_wb_we = 1'b0;

        // back-pressure: lw x10,4(x5) held for 3 cycles, then flushed
        @(posedge clk); #1;
        i_ready = 1'b0;
        send(32'h8CAA0004, 32'h210, mk(0, 0, 0, 0, 0, 0, 0), 0, 0, 0, w);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_valid", o_valid, 1);
            chk("stall_ready", o_ready, 0);
            chk("stall_DA", o_reg_DA, 32'h1234);
            chk("stall_imm", o_immediate, 4);
            chk("stall_ctrl", o_ctrl, 14'hC77);
        end
        @(posedge clk); #1;
        i_flush = 1'b1; i_valid = 1'b1; i_instruction = 32'h08000010; i_pcounter4 = 32'h214;
        @(negedge clk);
        chk("flush_ready", o_ready, 0);
        chk("flush_redirect", o_redirect, 0);
        @(posedge clk); #1;
        chk("flush_valid", o_valid, 0);
        i_flush = 1'b0; i_valid = 1'b0;

        // reset during a stall drops o_valid immediately and clears the register file
        send(32'h00A01820, 32'h300, mk(0, 0, 0, 0, 0, 0, 0), 0, 0, 0, w);
        chk("prerst_valid", o_valid, 1);
        i_rst_n = 1'b0;
        #1;
        chk("midrst_valid", o_valid, 0);
        chk("midrst_DA", o_reg_DA, 0);
        @(posedge clk); #1;
        i_rst_n = 1'b1; i_ready = 1'b1;
        send(32'h00A01820, 32'h304, mk(5, 0, 3, 0, 0, 32'h1820, 14'h1201), 1, 0, 0, w);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
